// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory op codes, RV funct3 values,
// FSM states and the latched request payload.
package load_store_unit_pkg;

  localparam logic [3:0] MEM_OP_IDLE = 4'b0000;
  localparam logic [3:0] MEM_OP_SW   = 4'b0001;
  localparam logic [3:0] MEM_OP_SH   = 4'b0010;
  localparam logic [3:0] MEM_OP_SB   = 4'b0011;
  localparam logic [3:0] MEM_OP_LW   = 4'b0100;
  localparam logic [3:0] MEM_OP_LH   = 4'b0101;
  localparam logic [3:0] MEM_OP_LB   = 4'b0110;
  localparam logic [3:0] MEM_OP_LHU  = 4'b0111;
  localparam logic [3:0] MEM_OP_LBU  = 4'b1000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_CHECK = 2'd1;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request validation: maps store/funct3 to a memory op code and
// flags illegal encodings, misalignment and accesses running past the memory end.
module lsu_req_check
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 12
) (
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic [3:0]  mem_op_c_o,
  output logic        err_c_o
);

  logic [2:0]  size_c;
  logic [3:0]  op_c;
  logic        illegal_c;
  logic        misalign_c;
  logic        range_c;
  logic [32:0] last_c;

  always_comb begin
    size_c     = 3'd1;
    op_c       = MEM_OP_IDLE;
    illegal_c  = 1'b0;
    misalign_c = 1'b0;
    case (funct3_i)
      F3_B: op_c = store_i ? MEM_OP_SB : MEM_OP_LB;
      F3_H: begin
        size_c     = 3'd2;
        op_c       = store_i ? MEM_OP_SH : MEM_OP_LH;
        misalign_c = addr_i[0];
      end
      F3_W: begin
        size_c     = 3'd4;
        op_c       = store_i ? MEM_OP_SW : MEM_OP_LW;
        misalign_c = |addr_i[1:0];
      end
      F3_BU: begin
        op_c      = MEM_OP_LBU;
        illegal_c = store_i;
      end
      F3_HU: begin
        size_c     = 3'd2;
        op_c       = MEM_OP_LHU;
        illegal_c  = store_i;
        misalign_c = addr_i[0];
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign last_c     = {1'b0, addr_i} + 33'(size_c) - 33'd1;
  assign range_c    = last_c >= 33'(MEM_BYTES);
  assign err_c_o    = illegal_c | misalign_c | range_c;
  assign mem_op_c_o = err_c_o ? MEM_OP_IDLE : op_c;

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one core load/store at a time, validates it,
// drives the memory op for the issue window and returns the load result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned MEM_BYTES = 12,
  parameter int unsigned MEM_WAIT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           mem_op,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 2);

  logic [STATE_W-1:0]   state_q, state_d;
  lsu_req_t             req_q, req_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [3:0]           mem_op_q, mem_op_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           chk_op_c;
  logic                 chk_err_c;

  lsu_req_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_check (
    .store_i    (req_q.store),
    .funct3_i   (req_q.funct3),
    .addr_i     (req_q.addr),
    .mem_op_c_o (chk_op_c),
    .err_c_o    (chk_err_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.store  = req_store;
          req_d.funct3 = req_funct3;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (chk_err_c) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          rsp_err_d   = 1'b0;
          mem_op_d    = chk_op_c;
          mem_addr_d  = req_q.addr[ADDR_BITS-1:0];
          mem_wdata_d = req_q.wdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_q.store) begin
          mem_op_d    = MEM_OP_IDLE;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(MEM_WAIT)) begin
          mem_op_d    = MEM_OP_IDLE;
          rsp_rdata_d = mem_rdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_op_q    <= MEM_OP_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
